reg_alu_seq: RTL and testbench

Instruction sequencer sitting directly upstream of the reg_alu datapath. It accepts 16-bit instruction words over a valid/ready stream and buffers them in a small FIFO. A multi-cycle FSM decodes each instruction and drives reg_alu's control inputs (wr, s, operation, read/write addresses) and its external data input. It captures reg_alu's cout into a carry flag and counts retired instructions.

---
 rtl/reg_alu_seq_if.sv | 40 ++++
 rtl/reg_alu_seq.sv | 149 ++++++++++++++
 tb/tb_reg_alu_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_alu_seq_if.sv
// Instruction stream, reg_alu control and status bundle for reg_alu_seq.
// Defining REG_ALU_SEQ_ILLEGAL_TRAP_EN adds the illegal status flag.
interface reg_alu_seq_if;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        wr;
    logic        s;
    logic [1:0]  operation;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_out;
    logic        cout;
    logic        carry_flag;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    modport slave (
        input  instr_in, instr_valid, cout,
        output instr_ready, wr, s, operation, rd_addr_a, rd_addr_b, wr_addr,
               d_out, carry_flag, busy, halted, retired
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport master (
        output instr_in, instr_valid, cout,
        input  instr_ready, wr, s, operation, rd_addr_a, rd_addr_b, wr_addr,
               d_out, carry_flag, busy, halted, retired
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/reg_alu_seq.sv
// Instruction FIFO plus multi-cycle decode FSM driving the reg_alu datapath.
// Optional REG_ALU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt and raise illegal.
module reg_alu_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    reg_alu_seq_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_IMM, S_LDW, S_EXEC, S_WB, S_HALTED
    } state_e;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_LDI  = 3'b001;
    localparam logic [2:0] OPC_ALU  = 3'b010;
    localparam logic [2:0] OPC_HALT = 3'b011;

    state_e         state_q, state_d;
    logic [15:0]    ir_q, ir_d;
    logic [15:0]    imm_q, imm_d;
    logic [15:0]    retired_q, retired_d;
    logic           carry_q, carry_d;
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [15:0]    fifo_mem [FIFO_DEPTH];
    logic [15:0]    fifo_head;
    logic           fifo_empty, fifo_full;
    logic           push, pop, retire;
    logic           unused_ir_bits;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
    logic           illegal_q, illegal_d;
`endif

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = bus.instr_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // NOTE: the storage array is deliberately not reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.instr_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_FETCH;
            ir_q      <= '0;
            imm_q     <= '0;
            retired_q <= '0;
            carry_q   <= 1'b0;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            retired_q <= retired_d;
            carry_q   <= carry_d;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        carry_d = carry_q;
        pop     = 1'b0;
        retire  = 1'b0;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ir_d    = fifo_head;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_q[15:13])
                    OPC_NOP:  begin retire = 1'b1; state_d = S_FETCH;  end
                    OPC_LDI:  state_d = S_IMM;
                    OPC_ALU:  state_d = S_EXEC;
                    OPC_HALT: begin retire = 1'b1; state_d = S_HALTED; end
                    default: begin
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_HALTED;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_IMM: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    imm_d   = fifo_head;
                    state_d = S_LDW;
                end
            end
            S_LDW:    begin retire = 1'b1; state_d = S_FETCH; end
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                carry_d = bus.cout;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
        retired_d = retired_q + {15'd0, retire};
    end

    assign bus.wr          = (state_q == S_LDW) || (state_q == S_WB);
    assign bus.s           = (state_q == S_LDW);
    assign bus.operation   = ((state_q == S_EXEC) || (state_q == S_WB)) ? ir_q[12:11] : 2'b00;
    assign bus.d_out       = (state_q == S_LDW) ? imm_q : 16'h0000;
    assign bus.wr_addr     = ir_q[10:8];
    assign bus.rd_addr_a   = ir_q[7:5];
    assign bus.rd_addr_b   = ir_q[4:2];
    assign bus.instr_ready = !fifo_full;
    assign bus.busy        = (state_q != S_FETCH) || !fifo_empty;
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.carry_flag  = carry_q;
    assign bus.retired     = retired_q;
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
    assign bus.illegal     = illegal_q;
`endif
    assign unused_ir_bits  = ^ir_q[1:0];
endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench for reg_alu_seq: directed vector table, hand-written
// multi-cycle sequences, and a randomized program against a program-level model.
module tb_reg_alu_seq;
    logic clk = 1'b0;
    logic reset;
    logic cout_force;
    int   n_pass  = 0;
    int   n_total = 0;

    reg_alu_seq_if bus();

    reg_alu_seq #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for reg_alu's carry: a fixed function of the operands it is shown.
    function automatic logic cout_fn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        return (int'(a) + int'(b) + int'(op)) > 7;
    endfunction

    assign bus.cout = cout_force ? 1'b1 : cout_fn(bus.rd_addr_a, bus.rd_addr_b, bus.operation);

    function automatic logic [27:0] ev(input logic s, input logic [2:0] a, input logic [15:0] d,
                                       input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb);
        return {s, a, d, op, ra, rb};
    endfunction

    function automatic logic [27:0] cur_ev();
        return ev(bus.s, bus.wr_addr, bus.d_out, bus.operation, bus.rd_addr_a, bus.rd_addr_b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        int guard = 0;
        bus.instr_in    = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!bus.instr_ready) check("push_ready", {31'd0, bus.instr_ready}, 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_in    = 16'h0000;
    endtask

    task automatic wait_wr(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.wr) break;
            tick();
        end
        check("wr_seen", {31'd0, bus.wr}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy || bus.halted) break;
            tick();
        end
        check("idle_reached", {31'd0, bus.busy && !bus.halted}, 32'd0);
    endtask

    // Write monitor and per-cycle output invariants for the random phase.
    logic        mon_en = 1'b0;
    logic [27:0] mon_q[$];
    int          inv_err = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wr) mon_q.push_back(cur_ev());
            if (bus.s && !bus.wr) inv_err++;
            if (!bus.s && bus.d_out != 16'h0000) inv_err++;
            if (bus.s && bus.operation != 2'b00) inv_err++;
            if (bus.wr && !bus.busy) inv_err++;
        end
    end

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          nwords;
        bit          has_write;
        logic [27:0] exp_ev;
        logic [15:0] exp_retired;
        bit          exp_halted;
        bit          exp_carry;
        bit          exp_illegal;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        logic [27:0] exp_q[$];
        logic [15:0] exp_retired;
        logic        exp_carry;
        logic [15:0] words[$];
        logic [15:0] w, imm;
        logic [12:0] low;
        int          bad, acc;
        logic        ready5;

        cout_force      = 1'b0;
        bus.instr_in    = 16'h0000;
        bus.instr_valid = 1'b0;
        reset_dut();

        check("rst_ctrl", {16'd0, bus.wr, bus.s, bus.operation, bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}, 32'd0);
        check("rst_dout", {16'd0, bus.d_out}, 32'd0);
        check("rst_status", {28'd0, bus.carry_flag, bus.busy, bus.halted, bus.instr_ready}, 32'd1);
        check("rst_retired", {16'd0, bus.retired}, 32'd0);

        // Single-instruction vectors with hand-derived expectations.
        tbl[0] = '{16'h2100, 16'h1234, 2, 1'b1, ev(1'b1, 3'd1, 16'h1234, 2'd0, 3'd0, 3'd0), 16'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h4328, 16'h0000, 1, 1'b1, ev(1'b0, 3'd3, 16'h0000, 2'd0, 3'd1, 3'd2), 16'd1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'h5ABC, 16'h0000, 1, 1'b1, ev(1'b0, 3'd2, 16'h0000, 2'd3, 3'd5, 3'd7), 16'd1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h27FC, 16'hFFFF, 2, 1'b1, ev(1'b1, 3'd7, 16'hFFFF, 2'd0, 3'd7, 3'd7), 16'd1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 1, 1'b0, 28'd0, 16'd1, 1'b0, 1'b0, 1'b0};
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
        tbl[5] = '{16'h8000, 16'h0000, 1, 1'b0, 28'd0, 16'd0, 1'b1, 1'b0, 1'b1};
`else
        tbl[5] = '{16'h8000, 16'h0000, 1, 1'b0, 28'd0, 16'd1, 1'b0, 1'b0, 1'b0};
`endif

        for (int i = 0; i < 6; i++) begin
            reset_dut();
            push(tbl[i].w0);
            if (tbl[i].nwords == 2) push(tbl[i].w1);
            if (tbl[i].has_write) begin
                wait_wr(20);
                check($sformatf("v%0d_write", i), {4'd0, cur_ev()}, {4'd0, tbl[i].exp_ev});
                tick();
                check($sformatf("v%0d_one_cycle", i), {31'd0, bus.wr}, 32'd0);
            end
            wait_idle(20);
            check($sformatf("v%0d_retired", i), {16'd0, bus.retired}, {16'd0, tbl[i].exp_retired});
            check($sformatf("v%0d_halted", i), {31'd0, bus.halted}, {31'd0, tbl[i].exp_halted});
            check($sformatf("v%0d_carry", i), {31'd0, bus.carry_flag}, {31'd0, tbl[i].exp_carry});
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
            check($sformatf("v%0d_illegal", i), {31'd0, bus.illegal}, {31'd0, tbl[i].exp_illegal});
`endif
        end

        // ALU cycle-by-cycle with cout tied high.
        reset_dut();
        cout_force = 1'b1;
        push(16'h4328);
        tick();
        tick();
        check("alu_exec", {24'd0, bus.wr, bus.rd_addr_a, bus.rd_addr_b, 1'b0}, {24'd0, 1'b0, 3'd1, 3'd2, 1'b0});
        tick();
        check("alu_wb", {24'd0, bus.wr, bus.s, bus.wr_addr, bus.operation, 1'b0}, {24'd0, 1'b1, 1'b0, 3'd3, 2'd0, 1'b0});
        tick();
        check("alu_after", {8'd0, bus.wr, bus.carry_flag, bus.retired, 6'd0}, {8'd0, 1'b0, 1'b1, 16'd1, 6'd0});

        // Reset asserted during WB of a second ALU instruction.
        push(16'h4328);
        tick();
        tick();
        tick();
        check("rst_wb_in_wb", {31'd0, bus.wr}, 32'd1);
        reset = 1'b1;
        tick();
        check("rst_wb_state", {12'd0, bus.wr, bus.carry_flag, bus.retired, bus.instr_ready, bus.busy},
                              {12'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0});
        reset = 1'b0;
        cout_force = 1'b0;

        // Immediate arriving long after its LDI.
        reset_dut();
        push(16'h2500);
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.wr || !bus.busy) bad++;
        end
        check("delay_hold", bad, 32'd0);
        push(16'hBEEF);
        wait_wr(10);
        check("delay_ldw", {4'd0, cur_ev()}, {4'd0, ev(1'b1, 3'd5, 16'hBEEF, 2'd0, 3'd0, 3'd0)});
        tick();
        check("delay_one_cycle", {15'd0, bus.wr, bus.retired}, {15'd0, 1'b0, 16'd1});

        // HALT, then overfill the FIFO.
        reset_dut();
        push(16'h6000);
        wait_idle(10);
        acc    = 0;
        ready5 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.instr_in    = 16'h1000 + 16'(k);
            bus.instr_valid = 1'b1;
            if (bus.instr_ready) acc++;
            if (k == 4) ready5 = bus.instr_ready;
            tick();
        end
        bus.instr_valid = 1'b0;
        check("full_accepted", acc, 32'd4);
        check("full_ready5", {31'd0, ready5}, 32'd0);
        check("full_halted", {15'd0, bus.halted, bus.retired}, {15'd0, 1'b1, 16'd1});

        // Random program versus a program-level model.
        reset_dut();
        exp_q.delete();
        words.delete();
        mon_q.delete();
        exp_retired = 16'd0;
        exp_carry   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            low = 13'($urandom);
            case ($urandom_range(0, 3))
                0: w = {3'b000, low};
                1: w = {3'b001, low};
                2: w = {3'b010, low};
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
                default: w = {3'b000, low};
`else
                default: w = {1'b1, 2'($urandom), low};
`endif
            endcase
            words.push_back(w);
            exp_retired++;
            if (w[15:13] == 3'b001) begin
                imm = 16'($urandom);
                words.push_back(imm);
                exp_q.push_back(ev(1'b1, w[10:8], imm, 2'd0, w[7:5], w[4:2]));
            end else if (w[15:13] == 3'b010) begin
                exp_q.push_back(ev(1'b0, w[10:8], 16'h0000, w[12:11], w[7:5], w[4:2]));
                exp_carry = cout_fn(w[7:5], w[4:2], w[12:11]);
            end
        end
        mon_en = 1'b1;
        foreach (words[j]) begin
            push(words[j]);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(1000);
        mon_en = 1'b0;
        check("rand_write_count", mon_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < mon_q.size(); j++)
            check($sformatf("rand_write%0d", j), {4'd0, mon_q[j]}, {4'd0, exp_q[j]});
        check("rand_retired", {16'd0, bus.retired}, {16'd0, exp_retired});
        check("rand_carry", {31'd0, bus.carry_flag}, {31'd0, exp_carry});
        check("rand_invariants", inv_err, 32'd0);
        push(16'h6000);
        wait_idle(10);
        check("rand_halt", {15'd0, bus.halted, bus.retired}, {15'd0, 1'b1, exp_retired + 16'd1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
